// File: rtl/mc_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mc_dmem_arbiter
// Purpose  : Round-robin arbiter that shares the single-port 32-bit data
//            memory between the CPU load/store unit and the client debug
//            port. It sequences each access through a small FSM and handles
//            byte/halfword/word lane steering and misalignment detection.
// Ports    : Clk/Rst            clock, async active-low reset
//            Cpu*               CPU request side (level request, Ack pulse)
//            Client*/CRDM/CWDM  client request side (mode-driven request)
//            Mem*               data-memory macro interface
//            MisalignErr, Busy  status
// Revision : 1.0 - initial release
// ============================================================================
module mc_dmem_arbiter #(
    parameter int LAT = 1,
    parameter int AW  = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CpuReq,
    input  logic          CpuWe,
    input  logic [1:0]    CpuMode,
    input  logic [AW-1:0] CpuAddr,
    input  logic [31:0]   CpuWData,
    output logic          CpuAck,
    output logic [31:0]   CpuRData,
    input  logic [AW-1:0] ClientMemAddr,
    input  logic [31:0]   ClientMemWrite,
    input  logic [1:0]    CRDM,
    input  logic [1:0]    CWDM,
    output logic          ClientAck,
    output logic [31:0]   ClientMemRead,
    output logic          MemEn,
    output logic          MemWe,
    output logic [3:0]    MemBE,
    output logic [AW-3:0] MemAddr,
    output logic [31:0]   MemWData,
    input  logic [31:0]   MemRData,
    output logic          MisalignErr,
    output logic          Busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // WAIT exits when the counter reaches LAT-2 (counter starts at 0).
    localparam logic [1:0] c_WAIT_LAST = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    function automatic logic [3:0] f_be(input logic [1:0] mode, input logic [1:0] lane);
        case (mode)
            2'd1:    f_be = 4'b0001 << lane;
            2'd2:    f_be = lane[1] ? 4'b1100 : 4'b0011;
            default: f_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] mode, input logic [31:0] wd);
        case (mode)
            2'd1:    f_wdata = {4{wd[7:0]}};
            2'd2:    f_wdata = {2{wd[15:0]}};
            default: f_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] f_rdata(input logic [1:0] mode, input logic [1:0] lane,
                                            input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {lane, 3'b000};
        case (mode)
            2'd1:    f_rdata = {24'h0, sh[7:0]};
            2'd2:    f_rdata = {16'h0, sh[15:0]};
            default: f_rdata = rd;
        endcase
    endfunction

    function automatic logic f_misalign(input logic [1:0] mode, input logic [1:0] lane);
        case (mode)
            2'd2:    f_misalign = lane[0];
            2'd3:    f_misalign = (lane != 2'd0);
            default: f_misalign = 1'b0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_cli_q, last_cli_d;   // 1 = client was granted last
    logic          cli_q, cli_d;             // current grant belongs to client
    logic          we_q, we_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   cli_rd_q, cli_rd_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [AW-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cli_ack_q, cli_ack_d;
    logic          mis_q, mis_d;
    logic          busy_q, busy_d;

    logic          cpu_req, cli_req, cli_wr, pick_cli;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    sel_mode;
    logic          sel_we;
    logic [31:0]   rd_word;

    // Request decode and grant selection.
    always_comb begin
        cpu_req   = CpuReq && (CpuMode != 2'd0);
        cli_wr    = (CWDM != 2'd0);
        cli_req   = cli_wr || (CRDM != 2'd0);
        // Client wins when alone, or when both request and the CPU went last.
        pick_cli  = cli_req && (!cpu_req || !last_cli_q);
        sel_addr  = pick_cli ? ClientMemAddr  : CpuAddr;
        sel_wdata = pick_cli ? ClientMemWrite : CpuWData;
        sel_we    = pick_cli ? cli_wr         : CpuWe;
        sel_mode  = pick_cli ? (cli_wr ? CWDM : CRDM) : CpuMode;
    end

    assign rd_word = f_rdata(mode_q, lane_q, MemRData);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_cli_d  = last_cli_q;
        cli_d       = cli_q;
        we_d        = we_q;
        mode_d      = mode_q;
        lane_d      = lane_q;
        cli_rd_d    = cli_rd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'h0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'h0;
        cpu_ack_d   = 1'b0;
        cli_ack_d   = 1'b0;
        mis_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || cli_req) begin
                    last_cli_d = pick_cli;
                    cli_d      = pick_cli;
                    we_d       = sel_we;
                    mode_d     = sel_mode;
                    lane_d     = sel_addr[1:0];
                    if (f_misalign(sel_mode, sel_addr[1:0])) begin
                        state_d   = S_ERR;
                        cpu_ack_d = !pick_cli;
                        cli_ack_d = pick_cli;
                        mis_d     = 1'b1;
                    end else begin
                        state_d     = S_ACC;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_be_d    = f_be(sel_mode, sel_addr[1:0]);
                        mem_addr_d  = sel_addr[AW-1:2];
                        mem_wdata_d = sel_we ? f_wdata(sel_mode, sel_wdata) : 32'h0;
                    end
                end
            end
            S_ACC: begin
                if (we_q || (LAT == 1)) begin
                    state_d   = S_ACK;
                    cpu_ack_d = !cli_q;
                    cli_ack_d = cli_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 2'd0;
                end
            end
            S_WAIT: begin
                if (cnt_q == c_WAIT_LAST) begin
                    state_d   = S_ACK;
                    cpu_ack_d = !cli_q;
                    cli_ack_d = cli_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (cli_q && !we_q) cli_rd_d = rd_word;
            end
            S_ERR: begin
                state_d = S_IDLE;
                if (cli_q && !we_q) cli_rd_d = 32'h0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            last_cli_q  <= 1'b1;
            cli_q       <= 1'b0;
            we_q        <= 1'b0;
            mode_q      <= 2'd0;
            lane_q      <= 2'd0;
            cli_rd_q    <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            cpu_ack_q   <= 1'b0;
            cli_ack_q   <= 1'b0;
            mis_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_cli_q  <= last_cli_d;
            cli_q       <= cli_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            lane_q      <= lane_d;
            cli_rd_q    <= cli_rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cli_ack_q   <= cli_ack_d;
            mis_q       <= mis_d;
            busy_q      <= busy_d;
        end
    end

    assign MemEn       = mem_en_q;
    assign MemWe       = mem_we_q;
    assign MemBE       = mem_be_q;
    assign MemAddr     = mem_addr_q;
    assign MemWData    = mem_wdata_q;
    assign CpuAck      = cpu_ack_q;
    assign ClientAck   = cli_ack_q;
    assign MisalignErr = mis_q;
    assign Busy        = busy_q;

    // Read data arrives from the macro during the Ack cycle itself, so it is
    // steered combinationally; misaligned reads return zero.
    assign CpuRData      = (cpu_ack_q && !we_q && !mis_q) ? rd_word : 32'h0;
    assign ClientMemRead = (cli_ack_q && !we_q) ? (mis_q ? 32'h0 : rd_word) : cli_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_dmem_arbiter
// Purpose  : Self-checking bench for mc_dmem_arbiter. Two instances (LAT=1 and
//            LAT=3), each with its own memory macro model, checked against a
//            byte-array reference memory and timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_dmem_arbiter;

    logic        Clk;
    logic        Rst            [2];
    logic        CpuReq         [2];
    logic        CpuWe          [2];
    logic [1:0]  CpuMode        [2];
    logic [31:0] CpuAddr        [2];
    logic [31:0] CpuWData       [2];
    logic        CpuAck         [2];
    logic [31:0] CpuRData       [2];
    logic [31:0] ClientMemAddr  [2];
    logic [31:0] ClientMemWrite [2];
    logic [1:0]  CRDM           [2];
    logic [1:0]  CWDM           [2];
    logic        ClientAck      [2];
    logic [31:0] ClientMemRead  [2];
    logic        MemEn          [2];
    logic        MemWe          [2];
    logic [3:0]  MemBE          [2];
    logic [29:0] MemAddr        [2];
    logic [31:0] MemWData       [2];
    logic [31:0] MemRData       [2];
    logic        MisalignErr    [2];
    logic        Busy           [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [2][65536] = '{default: 8'h00};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    for (genvar i = 0; i < 2; i++) begin : g_env
        mc_dmem_arbiter #(.LAT((i == 0) ? 1 : 3), .AW(32)) u_dut (
            .Clk(Clk), .Rst(Rst[i]),
            .CpuReq(CpuReq[i]), .CpuWe(CpuWe[i]), .CpuMode(CpuMode[i]),
            .CpuAddr(CpuAddr[i]), .CpuWData(CpuWData[i]),
            .CpuAck(CpuAck[i]), .CpuRData(CpuRData[i]),
            .ClientMemAddr(ClientMemAddr[i]), .ClientMemWrite(ClientMemWrite[i]),
            .CRDM(CRDM[i]), .CWDM(CWDM[i]),
            .ClientAck(ClientAck[i]), .ClientMemRead(ClientMemRead[i]),
            .MemEn(MemEn[i]), .MemWe(MemWe[i]), .MemBE(MemBE[i]),
            .MemAddr(MemAddr[i]), .MemWData(MemWData[i]), .MemRData(MemRData[i]),
            .MisalignErr(MisalignErr[i]), .Busy(Busy[i])
        );

        // Memory macro: read data appears LAT edges after the MemEn edge.
        logic [31:0] mem  [16384] = '{default: 32'h0};
        logic [31:0] pipe [4]     = '{default: 32'h0};
        always @(posedge Clk) begin
            if (MemEn[i]) begin
                if (MemWe[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (MemBE[i][b]) mem[MemAddr[i][13:0]][8*b +: 8] <= MemWData[i][8*b +: 8];
                end else begin
                    pipe[0] <= mem[MemAddr[i][13:0]];
                end
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign MemRData[i] = pipe[(i == 0) ? 0 : 2];
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drop_req(input int d);
        CpuReq[d] = 1'b0; CpuMode[d] = 2'd0; CpuWe[d] = 1'b0;
        CRDM[d] = 2'd0; CWDM[d] = 2'd0;
    endtask

    // Drive one request in cycle 0 and observe the DUT until its Ack.
    task automatic do_acc(input int d, input bit cli, input bit we, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdat, output int ackc, output bit mis,
                          output int nen, output logic [3:0] be, output logic [31:0] mwd,
                          output logic [29:0] maddr, output bit mwe, output int stray,
                          output int bad, output logic [31:0] hold);
        rdat = 0; ackc = -1; mis = 0; nen = 0; be = 0; mwd = 0; maddr = 0; mwe = 0;
        stray = 0; bad = 0;
        @(posedge Clk); #1;
        if (cli) begin
            ClientMemAddr[d] = addr; ClientMemWrite[d] = wd;
            if (we) CWDM[d] = mode; else CRDM[d] = mode;
        end else begin
            CpuReq[d] = 1'b1; CpuWe[d] = we; CpuMode[d] = mode;
            CpuAddr[d] = addr; CpuWData[d] = wd;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (MemEn[d]) begin
                nen++; be = MemBE[d]; mwd = MemWData[d]; maddr = MemAddr[d]; mwe = MemWe[d];
            end
            if (!CpuAck[d] && CpuRData[d] != 32'h0) bad++;
            if (cli ? CpuAck[d] : ClientAck[d]) stray++;
            if (cli ? ClientAck[d] : CpuAck[d]) begin
                ackc = n; mis = MisalignErr[d];
                rdat = cli ? ClientMemRead[d] : CpuRData[d];
                break;
            end
        end
        drop_req(d);
        @(negedge Clk);
        hold = ClientMemRead[d];
        if (CpuRData[d] != 32'h0) bad++;
    endtask

    // Access checked against the reference memory and timing rules.
    task automatic acc_chk(input int d, input bit cli, input bit we, input logic [1:0] mode,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd);
        int sz, e_ack, ackc, nen, stray, bad;
        bit e_mis, mis, mwe;
        logic [3:0] e_be, be;
        logic [31:0] e_wd, e_rd, r, mwd, hold;
        logic [29:0] maddr;
        logic [15:0] ba;
        sz    = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 4;
        e_mis = (addr % sz) != 0;
        e_be  = 4'(((1 << sz) - 1) << (addr % 4));
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        e_rd = 32'h0;
        if (!e_mis && !we)
            for (int k = 0; k < sz; k++) begin
                ba = 16'(addr + k);
                e_rd = e_rd | (32'(ref_mem[d][ba]) << (8 * k));
            end
        e_ack = e_mis ? 1 : (we ? 2 : 1 + lat_of(d));
        do_acc(d, cli, we, mode, addr, wd, r, ackc, mis, nen, be, mwd, maddr, mwe, stray, bad, hold);
        check("ack_cycle", 32'(ackc), 32'(e_ack));
        check("misalign", 32'(mis), 32'(e_mis));
        check("mem_en_count", 32'(nen), e_mis ? 32'd0 : 32'd1);
        check("stray_ack", 32'(stray), 32'd0);
        check("rdata_idle_zero", 32'(bad), 32'd0);
        if (!e_mis) begin
            check("mem_be", 32'(be), 32'(e_be));
            check("mem_addr", 32'(maddr), 32'(addr[31:2]));
            check("mem_we", 32'(mwe), 32'(we));
            if (we) check("mem_wdata", mwd, e_wd);
        end
        if (!we) check("rdata", r, e_rd);
        if (cli && !we) check("client_hold", hold, e_rd);
        if (we && !e_mis)
            for (int k = 0; k < sz; k++) begin
                ba = 16'(addr + k);
                ref_mem[d][ba] = wd[8*k +: 8];
            end
        rd = r;
    endtask

    task automatic reset_checks(input int d);
        check("rst_busy", 32'(Busy[d]), 0);
        check("rst_acks", {30'h0, CpuAck[d], ClientAck[d]}, 0);
        check("rst_mem_strobes", {27'h0, MemEn[d], MemWe[d], MemBE[d]}, 0);
        check("rst_mem_addr", 32'(MemAddr[d]), 0);
        check("rst_mem_wdata", MemWData[d], 0);
        check("rst_misalign", 32'(MisalignErr[d]), 0);
        check("rst_client_read", ClientMemRead[d], 0);
        check("rst_cpu_rdata", CpuRData[d], 0);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [31:0] exp_b [4];
        int order [4];
        int nack, busy_low, acks_seen;
        bit started;

        exp_b = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int d = 0; d < 2; d++) begin
            Rst[d] = 1'b0; drop_req(d);
            CpuAddr[d] = 0; CpuWData[d] = 0; ClientMemAddr[d] = 0; ClientMemWrite[d] = 0;
        end
        repeat (3) @(negedge Clk);
        reset_checks(0); reset_checks(1);
        Rst[0] = 1'b1; Rst[1] = 1'b1;
        @(negedge Clk);

        // Word write/read through the CPU.
        acc_chk(0, 0, 1, 2'd3, 32'h4, 32'h44332211, rd);
        acc_chk(0, 0, 0, 2'd3, 32'h4, 32'h0, rd);
        check("t1_word_read", rd, 32'h44332211);

        // Client byte and halfword reads.
        for (int i = 0; i < 4; i++) begin
            acc_chk(0, 1, 0, 2'd1, 32'(4 + i), 32'h0, rd);
            check("t2_byte_read", rd, exp_b[i]);
        end
        acc_chk(0, 1, 0, 2'd2, 32'h6, 32'h0, rd);
        check("t2_half_read", rd, 32'h00004433);

        // Client byte write then word read.
        acc_chk(0, 1, 1, 2'd1, 32'h8001, 32'hAB, rd);
        acc_chk(0, 1, 0, 2'd3, 32'h8000, 32'h0, rd);
        check("t3_word_read", rd, 32'h0000AB00);

        // Misaligned accesses.
        acc_chk(0, 0, 0, 2'd3, 32'h8002, 32'h0, rd);
        acc_chk(0, 1, 0, 2'd2, 32'h8003, 32'h0, rd);

        // Round-robin with both requesters held, straight out of reset.
        @(negedge Clk); Rst[0] = 1'b0;
        repeat (2) @(negedge Clk); Rst[0] = 1'b1;
        @(posedge Clk); #1;
        CpuReq[0] = 1'b1; CpuWe[0] = 1'b0; CpuMode[0] = 2'd3; CpuAddr[0] = 32'h4;
        CRDM[0] = 2'd3; ClientMemAddr[0] = 32'h8;
        nack = 0; busy_low = 0; started = 0;
        for (int n = 0; n < 40 && nack < 4; n++) begin
            @(negedge Clk);
            if (Busy[0]) started = 1;
            else if (started) busy_low++;
            if (CpuAck[0] && ClientAck[0]) order[nack++] = 2;
            else if (CpuAck[0]) order[nack++] = 0;
            else if (ClientAck[0]) order[nack++] = 1;
        end
        drop_req(0);
        check("t4_ack_count", 32'(nack), 4);
        for (int i = 0; i < 4; i++) check("t4_grant_order", 32'(order[i]), 32'(i % 2));
        check("t4_idle_cycles", 32'(busy_low), 3);
        @(negedge Clk);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++)
            for (int t = 0; t < 60; t++)
                acc_chk(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(1, 3)), 32'($urandom_range(0, 16'hFFFF)),
                        $urandom, rd);

        // LAT=3 read timing, then reset during WAIT.
        acc_chk(1, 0, 1, 2'd3, 32'h10, 32'hCAFEF00D, rd);
        acc_chk(1, 0, 0, 2'd3, 32'h10, 32'h0, rd);
        check("t6_read", rd, 32'hCAFEF00D);
        @(posedge Clk); #1;
        CpuReq[1] = 1'b1; CpuWe[1] = 1'b0; CpuMode[1] = 2'd3; CpuAddr[1] = 32'h10;
        @(negedge Clk);
        @(negedge Clk);
        check("t6_acc_en", 32'(MemEn[1]), 1);
        @(negedge Clk);
        check("t6_wait_busy", 32'(Busy[1]), 1);
        Rst[1] = 1'b0;
        #1;
        check("t6_rst_busy", 32'(Busy[1]), 0);
        check("t6_rst_outs", {29'h0, MemEn[1], CpuAck[1], ClientAck[1]}, 0);
        drop_req(1);
        acks_seen = 0;
        repeat (3) begin
            @(negedge Clk);
            if (CpuAck[1] || ClientAck[1]) acks_seen++;
        end
        Rst[1] = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (CpuAck[1] || ClientAck[1]) acks_seen++;
        end
        check("t6_no_ack", 32'(acks_seen), 0);
        check("t6_idle", 32'(Busy[1]), 0);
        acc_chk(1, 0, 0, 2'd3, 32'h10, 32'h0, rd);
        check("t6_after_reset", rd, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_dmem_arbiter.md
Name: mc_dmem_arbiter

Overview:
- Shares the MiniComputer single-port 32-bit data memory between two requesters: the CPU load/store unit and the external client debug port (ClientMemAddr/ClientMemWrite/CRDM/CWDM/ClientMemRead).
- Arbitrates between them round-robin and sequences each access through a small FSM.
- Handles byte, halfword and word sizing, lane alignment and misalignment detection.
- Sits between the CPU/client logic and the data-memory macro.

Parameters:
LAT, 1, memory read latency in cycles from MemEn to valid MemRData (legal 1..4)
AW, 32, byte-address width of both requesters

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-low reset
CpuReq  in  1  CPU access request (level, held until CpuAck)
CpuWe  in  1  1=write, 0=read
CpuMode  in  2  0=none, 1=byte, 2=halfword, 3=word
CpuAddr  in  AW  CPU byte address
CpuWData  in  32  CPU write data, right-aligned
CpuAck  out  1  one-cycle completion pulse
CpuRData  out  32  read data, zero-extended, valid while CpuAck=1
ClientMemAddr  in  AW  client byte address
ClientMemWrite  in  32  client write data, right-aligned
CRDM  in  2  client read mode (same encoding as CpuMode)
CWDM  in  2  client write mode (same encoding)
ClientAck  out  1  one-cycle completion pulse
ClientMemRead  out  32  client read data, holds last completed client read
MemEn  out  1  memory access strobe
MemWe  out  1  memory write enable
MemBE  out  4  byte enables, bit n = byte lane n
MemAddr  out  AW-2  word address (Addr[AW-1:2])
MemWData  out  32  lane-replicated write data
MemRData  in  32  memory read data
MisalignErr  out  1  pulses with Ack on a misaligned request
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset: Rst=0 forces the FSM to IDLE immediately. All outputs are 0; ClientMemRead is 0. LastGrant is set to client.
- Reset mid-operation: the in-flight access is dropped and no Ack is issued.
- Request detection:
  - CPU requests when CpuReq=1 and CpuMode!=0.
  - Client requests when CWDM!=0 (write, size=CWDM) or else CRDM!=0 (read, size=CRDM). CWDM has priority over CRDM.
- Arbitration (IDLE only): a sole requester is granted. If both request, the requester not granted last wins. LastGrant updates on every grant.
- Address, data, mode and direction are latched at grant. Requester inputs are don't-care until Ack.
- FSM: IDLE -> ACC -> (WAIT x LAT-1, reads only) -> ACK -> IDLE; misaligned requests go IDLE -> ERR -> IDLE.
  - IDLE: no strobes. On grant, go to ACC (aligned) or ERR (misaligned).
  - ACC: MemEn=1 for exactly one cycle with MemAddr, MemBE and MemWe.
    - Write: go to ACK.
    - Read: go to ACK if LAT=1, else to WAIT.
  - WAIT: a counter runs LAT-1 cycles, then goes to ACK.
  - ACK: the granted requester's Ack=1 for one cycle. Read data is captured from MemRData in this cycle. Next state is IDLE.
  - ERR: Ack=1 and MisalignErr=1 for one cycle. Read data = 0. MemEn is never asserted. Next state is IDLE.
- Timing (grant edge = cycle 0):
  - Write: Ack in cycle 2.
  - Read: Ack in cycle 1+LAT.
  - Misaligned: Ack in cycle 1.
  - Minimum request-to-request spacing per requester = Ack cycle + 1.
- Alignment: byte accepts any address. Halfword requires Addr[0]=0. Word requires Addr[1:0]=0.
- Lanes (little-endian, L=Addr[1:0]):
  - Byte: MemBE=1<<L; MemWData = WData[7:0] replicated x4; read = {24'h0, MemRData[8L+7:8L]}.
  - Halfword: MemBE = L[1] ? 4'b1100 : 4'b0011; MemWData = WData[15:0] replicated x2; read = zero-extended selected half.
  - Word: MemBE=4'hF; MemWData and read data unchanged.
- Reads: MemBE still reflects the size; MemWe=0.
- A held client request is re-granted after ClientAck. The client must change or drop its request after ClientAck; a re-performed write is identical.
- CpuRData is 0 outside CpuAck.

Test Plan:
1. LAT=1: CPU word write 0x44332211 to address 0x4. Expect MemEn/MemWe pulse with MemAddr=1, MemBE=F, then CpuAck in cycle 2. CPU word read of 0x4 returns 0x44332211 with CpuAck in cycle 2.
2. Client byte reads with CRDM=1 at 0x4,0x5,0x6,0x7. Expect ClientMemRead = 0x11, 0x22, 0x33, 0x44 zero-extended, with MemBE = 1, 2, 4, 8. Halfword read (CRDM=2) at 0x6 returns 0x00004433.
3. Client byte write with CWDM=1, ClientMemWrite=0xAB at 0x8001. Expect MemBE=4'b0010 and MemWData=0xABABABAB. A following word read of 0x8000 shows 0x0000AB00 (memory zero-initialised).
4. After reset, CpuReq and client CRDM=3 asserted together and held. Expect grants CPU, client, CPU, client; Busy continuously high apart from one IDLE cycle between grants.
5. CPU word read at 0x8002 and client halfword read at 0x8003. Each gives Ack with MisalignErr=1 and read data 0 in cycle 1; MemEn never asserted.
6. LAT=3: CPU read Ack arrives in cycle 4. Assert Rst=0 during WAIT: outputs clear immediately, no CpuAck; after release the FSM is IDLE and the next request is serviced normally.
